// File: rtl/decrypt_pipe_pkg.sv
// decrypt_pipe_pkg
//   Cipher parameters and helper functions for the PRESENT-80 decryption
//   pipeline: S-box tables, inverse permutation layer, forward/inverse key
//   schedule step and round-key extraction.
//   No ports; imported by decrypt_pipe and decrypt_pipe_round.
package decrypt_pipe_pkg;

  localparam int N_B = 64;            // block width
  localparam int N_K = 80;            // key width
  localparam int N_R = 31;            // rounds
  localparam int N_L = 2 * N_R + 2;   // decrypt latency in cycles

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // Nibbles are consumed from the bottom and shifted in at the top, so after
  // all N_B/4 steps each result sits back in its original nibble position.
  function automatic logic [N_B-1:0] inv_sbox_layer(input logic [N_B-1:0] s);
    logic [N_B-1:0] t;
    logic [N_B-1:0] o;
    t = s;
    o = '0;
    for (int n = 0; n < N_B / 4; n++) begin
      o = {inv_sbox(t[3:0]), o[N_B-1:4]};
      t = t >> 4;
    end
    return o;
  endfunction

  // Forward layer moves bit i to (16*i) mod 63 (bit 63 fixed); the inverse
  // gathers each output bit back from that position.
  function automatic logic [N_B-1:0] inv_p_layer(input logic [N_B-1:0] s);
    logic [N_B-1:0] o;
    logic [5:0]     dst;
    logic [5:0]     src;
    o = '0;
    for (int i = 0; i < N_B - 1; i++) begin
      dst    = 6'(i);
      src    = 6'((i * 16) % (N_B - 1));
      o[dst] = s[src];
    end
    o[N_B-1] = s[N_B-1];
    return o;
  endfunction

  // Rotate left by 61, S-box the top nibble, XOR the counter into bits 19:15.
  function automatic logic [N_K-1:0] key_update(input logic [N_K-1:0] key,
                                                input logic [4:0]     r);
    logic [N_K-1:0] t;
    t           = {key[18:0], key[N_K-1:19]};
    t[N_K-1 -: 4] = sbox(t[N_K-1 -: 4]);
    t[19:15]    = t[19:15] ^ r;
    return t;
  endfunction

  // Undo key_update in reverse order: counter XOR, inverse S-box, rotate right by 61.
  function automatic logic [N_K-1:0] inv_key_update(input logic [N_K-1:0] key,
                                                    input logic [4:0]     r);
    logic [N_K-1:0] t;
    t           = key;
    t[19:15]    = t[19:15] ^ r;
    t[N_K-1 -: 4] = inv_sbox(t[N_K-1 -: 4]);
    return {t[60:0], t[N_K-1:61]};
  endfunction

  function automatic logic [N_B-1:0] rk(input logic [N_K-1:0] key);
    return key[N_K-1 -: N_B];
  endfunction

endpackage

// File: rtl/decrypt_pipe_round.sv
// decrypt_pipe_round
//   One registered inverse round. Strips round key rk(key), applies the
//   inverse permutation and inverse S-box, and steps the key schedule back
//   by one using the stage-constant counter J.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     v, state, key   incoming valid / cipher state / round key register
//     v_q, state_q,   registered outputs; data holds when v=0
//     key_q
module decrypt_pipe_round
  import decrypt_pipe_pkg::*;
#(
  parameter logic [4:0] J = 5'd1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           v,
  input  logic [N_B-1:0] state,
  input  logic [N_K-1:0] key,
  output logic           v_q,
  output logic [N_B-1:0] state_q,
  output logic [N_K-1:0] key_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= 1'b0;
      state_q <= '0;
      key_q   <= '0;
    end else begin
      v_q <= v;
      if (v) begin
        state_q <= inv_sbox_layer(inv_p_layer(state ^ rk(key)));
        key_q   <= inv_key_update(key, J);
      end
    end
  end

endmodule

// File: rtl/decrypt_pipe.sv
// decrypt_pipe
//   Fully pipelined PRESENT-80 decryption. The cipher key is expanded
//   forward to the last round key, then N_R inverse rounds walk the schedule
//   back down to K1 for the final whitening. One block per cycle, fixed
//   latency N_L, no backpressure.
//   Ports:
//     clk, rst   clock, synchronous active-high reset
//     v_i        input valid (k and c sampled only when set)
//     k          cipher key, c ciphertext
//     v_o        output valid, m recovered plaintext (holds while v_o=0)
module decrypt_pipe
  import decrypt_pipe_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           v_i,
  input  logic [N_K-1:0] k,
  input  logic [N_B-1:0] c,
  output logic           v_o,
  output logic [N_B-1:0] m
);

  logic           ks_v   [N_R+1];
  logic [N_K-1:0] ks_key [N_R+1];
  logic [N_B-1:0] ks_c   [N_R+1];

  logic           d_v     [N_R+1];
  logic [N_B-1:0] d_state [N_R+1];
  logic [N_K-1:0] d_key   [N_R+1];

  logic           in_v;
  logic [N_K-1:0] in_key;
  logic [N_B-1:0] in_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_v   <= 1'b0;
      in_key <= '0;
      in_c   <= '0;
    end else begin
      in_v <= v_i;
      if (v_i) begin
        in_key <= k;
        in_c   <= c;
      end
    end
  end

  assign ks_v[0]   = in_v;
  assign ks_key[0] = in_key;
  assign ks_c[0]   = in_c;

  // Forward expansion: stage g turns K(g) into K(g+1).
  for (genvar g = 1; g <= N_R; g++) begin : g_ks
    logic           v_r;
    logic [N_K-1:0] key_r;
    logic [N_B-1:0] c_r;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_r   <= 1'b0;
        key_r <= '0;
        c_r   <= '0;
      end else begin
        v_r <= ks_v[g-1];
        if (ks_v[g-1]) begin
          key_r <= key_update(ks_key[g-1], 5'(g));
          c_r   <= ks_c[g-1];
        end
      end
    end

    assign ks_v[g]   = v_r;
    assign ks_key[g] = key_r;
    assign ks_c[g]   = c_r;
  end

  assign d_v[0]     = ks_v[N_R];
  assign d_state[0] = ks_c[N_R];
  assign d_key[0]   = ks_key[N_R];

  // Inverse round i consumes K(j+1) and leaves K(j), j = N_R+1-i.
  for (genvar i = 1; i <= N_R; i++) begin : g_dec
    decrypt_pipe_round #(
      .J(5'(N_R + 1 - i))
    ) u_round (
      .clk     (clk),
      .rst     (rst),
      .v       (d_v[i-1]),
      .state   (d_state[i-1]),
      .key     (d_key[i-1]),
      .v_q     (d_v[i]),
      .state_q (d_state[i]),
      .key_q   (d_key[i])
    );
  end

  // Key register now holds K1: final whitening.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_o <= 1'b0;
      m   <= '0;
    end else begin
      v_o <= d_v[N_R];
      if (d_v[N_R]) begin
        m <= d_state[N_R] ^ rk(d_key[N_R]);
      end
    end
  end

endmodule

// File: tb/tb_decrypt_pipe.sv
// tb_decrypt_pipe
//   Directed bench for decrypt_pipe using the published PRESENT-80 vectors.
//   Inputs are driven and outputs sampled on the falling edge; an input
//   driven at falling edge t is expected at the output at falling edge t+64.
module tb_decrypt_pipe;

  localparam int NL = 64;

  localparam logic [79:0] VK [4] = '{80'h0, {80{1'b1}}, 80'h0, {80{1'b1}}};
  localparam logic [63:0] VC [4] = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
                                     64'hA112FFC72F68417B, 64'h3333DCD3213210D2};
  localparam logic [63:0] VM [4] = '{64'h0, 64'h0, {64{1'b1}}, {64{1'b1}}};

  logic        clk = 1'b0;
  logic        rst;
  logic        v_i;
  logic [79:0] k;
  logic [63:0] c;
  logic        v_o;
  logic [63:0] m;

  int errors = 0;
  int checks = 0;

  decrypt_pipe dut (
    .clk (clk),
    .rst (rst),
    .v_i (v_i),
    .k   (k),
    .c   (c),
    .v_o (v_o),
    .m   (m)
  );

  always #5 clk = ~clk;

  // Reset asserted together with valid input: reset must win.
  task automatic test_reset();
    rst = 1'b1; v_i = 1'b1; k = VK[3]; c = VC[3];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; v_i = 1'b0; k = '0; c = '0;
    for (int t = 1; t <= 70; t++) begin
      @(negedge clk);
      checks++;
      if (v_o !== 1'b0) begin
        errors++; $display("FAIL reset_v_o t=%0d got %b want 0", t, v_o);
      end
      checks++;
      if (m !== 64'h0) begin
        errors++; $display("FAIL reset_m t=%0d got %h want 0", t, m);
      end
    end
  endtask

  task automatic test_single();
    logic exp_v;
    for (int t = 0; t <= 70; t++) begin
      if (t > 0) begin
        exp_v = 1'(t == NL);
        checks++;
        if (v_o !== exp_v) begin
          errors++; $display("FAIL single_v_o t=%0d got %b want %b", t, v_o, exp_v);
        end
        if (t >= NL) begin
          checks++;
          if (m !== VM[0]) begin
            errors++; $display("FAIL single_m t=%0d got %h want %h", t, m, VM[0]);
          end
        end
      end
      if (t == 0) begin
        v_i = 1'b1; k = VK[0]; c = VC[0];
      end else begin
        v_i = 1'b0; k = '0; c = '0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [63:0] exp_m;
    for (int t = 0; t <= 72; t++) begin
      if (t > 0) begin
        exp_v = 1'(t >= NL && t < NL + 4);
        checks++;
        if (v_o !== exp_v) begin
          errors++; $display("FAIL b2b_v_o t=%0d got %b want %b", t, v_o, exp_v);
        end
        if (t >= NL) begin
          exp_m = (t < NL + 4) ? VM[t-NL] : VM[3];
          checks++;
          if (m !== exp_m) begin
            errors++; $display("FAIL b2b_m t=%0d got %h want %h", t, m, exp_m);
          end
        end
      end
      if (t < 4) begin
        v_i = 1'b1; k = VK[t]; c = VC[t];
      end else begin
        v_i = 1'b0; k = '0; c = '0;
      end
      @(negedge clk);
    end
  endtask

  // Valid pattern 1,0,1,1,0,1; data chosen so each accepted block changes m.
  task automatic test_bubbles();
    localparam logic PV [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    localparam int   SEL [6] = '{0, 0, 2, 1, 0, 3};
    logic        exp_v;
    logic [63:0] exp_m;
    exp_m = VM[3];
    for (int t = 0; t <= 76; t++) begin
      if (t > 0) begin
        exp_v = 1'b0;
        if (t >= NL && t < NL + 6) begin
          exp_v = PV[t-NL];
          if (exp_v) exp_m = VM[SEL[t-NL]];
        end
        checks++;
        if (v_o !== exp_v) begin
          errors++; $display("FAIL bubble_v_o t=%0d got %b want %b", t, v_o, exp_v);
        end
        checks++;
        if (m !== exp_m) begin
          errors++; $display("FAIL bubble_m t=%0d got %h want %h", t, m, exp_m);
        end
      end
      if (t < 6 && PV[t]) begin
        v_i = 1'b1; k = VK[SEL[t]]; c = VC[SEL[t]];
      end else begin
        v_i = 1'b0; k = 'z; c = 'z;
      end
      @(negedge clk);
    end
    k = '0; c = '0;
  endtask

  // Three blocks in flight, reset at t=22, then a fresh block at t=30.
  task automatic test_reset_midflight();
    logic        exp_v;
    logic [63:0] exp_m;
    for (int t = 0; t <= 100; t++) begin
      if (t > 0) begin
        exp_v = 1'(t == 30 + NL);
        if (t <= 22)          exp_m = VM[3];
        else if (t < 30 + NL) exp_m = 64'h0;
        else                  exp_m = VM[3];
        checks++;
        if (v_o !== exp_v) begin
          errors++; $display("FAIL midrst_v_o t=%0d got %b want %b", t, v_o, exp_v);
        end
        checks++;
        if (m !== exp_m) begin
          errors++; $display("FAIL midrst_m t=%0d got %h want %h", t, m, exp_m);
        end
      end
      rst = 1'(t == 22);
      if (t < 3) begin
        v_i = 1'b1; k = VK[t]; c = VC[t];
      end else if (t == 30) begin
        v_i = 1'b1; k = VK[3]; c = VC[3];
      end else begin
        v_i = 1'b0; k = '0; c = '0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_bubbles();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decrypt_pipe.md
Name: decrypt_pipe

Overview:
- Fully pipelined inverse of encrypt_pipe for the cipher configured in params.h (PRESENT-80 in the current configuration: N_B=64, N_K=80, N_R=31).
- Accepts one (key, ciphertext) pair per cycle and produces the matching plaintext a fixed N_L cycles later, with a valid bit travelling alongside.
- Decryption needs the final round key, so the pipeline has two parts: a forward key-expansion section, then an inverse-round section. This avoids any precomputed key input.
- Sits beside encrypt_pipe in the datapath and is verified against the same vectors_k/m/c files, with the roles of m and c swapped.

Parameters:
- N_B, 64, block width (params.h macro).
- N_K, 80, cipher key width (params.h macro).
- N_R, 31, number of rounds (params.h macro).
- N_L, 2*N_R+2 = 64, decrypt latency in cycles; new macro added to params.h.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- v_i  in  1  input valid; k and c are sampled when v_i=1.
- k    in  N_K  cipher key (the same key that was used to encrypt).
- c    in  N_B  ciphertext.
- v_o  out  1  output valid.
- m    out  N_B  recovered plaintext.

Behaviour:
- Stage 0, input register: captures {v_i, k, c}.
- Stages KS1..KS(N_R), forward key expansion:
  - key <= key_update(key, r) for r = 1..N_R.
  - Ciphertext and valid pass through unchanged.
  - After KS(N_R), the key register holds K(N_R+1).
- Stages D1..D(N_R), inverse rounds. Stage Di with j = N_R+1-i:
  - state <= inv_sbox_layer(inv_p_layer(state ^ rk(key)))
  - key <= inv_key_update(key, j)
  - rk(key) = key[N_K-1 -: N_B]
- Output stage: m <= state ^ rk(key), which applies the K1 whitening. v_o <= valid.
- Total latency: exactly N_L = 2+2*N_R = 64 cycles. A pair presented with v_i=1 at edge t appears with v_o=1 after edge t+N_L.
- Throughput is one block per cycle. There is no backpressure; the downstream consumer must always accept.
- Each stage's data registers load only when that stage's incoming valid bit is 1, otherwise they hold. Consequences:
  - m holds the last valid plaintext while v_o=0.
  - X or Z values on k and c with v_i=0 never reach m.
- Valid bits shift unconditionally every cycle, so bubbles are preserved exactly.
- Round counters are stage constants. There is no runtime counter.
- Reset (synchronous, rst=1 at a rising edge):
  - All valid bits, all data and key registers, m and v_o clear to 0.
  - A reset in mid-operation discards every in-flight block. No stale v_o=1 may appear afterwards.
  - Inputs presented in the reset cycle are ignored.
- If rst=1 and v_i=1 in the same cycle, reset wins.
- Key-schedule counter arithmetic is 5-bit and XORed into the key bits defined by the cipher's schedule. inv_key_update is the exact inverse of key_update for the same counter value.
- Rotations are modulo N_K. There is no other width growth; all datapaths are exactly N_B or N_K bits.

Decomposition:
- Shared include cipher_fn.vh, used by both encrypt_pipe and decrypt_pipe. It contains:
  - sbox / inv_sbox tables.
  - p_layer / inv_p_layer functions.
  - key_update / inv_key_update(key, r) functions.
  - rk(key).
- params.h gains N_L.
- Natural sub-module: decrypt_round. It is one registered Di stage with ports clk, rst, v, state, key, a constant round parameter, and registered outputs. It is instantiated N_R times with a generate loop.
- The KS stages stay inline in the top level; they are a trivial per-stage key_update register.

Test Plan:
- Reset:
  - Stimulus: rst=1 for 2 cycles, then v_i=0 for 70 cycles.
  - Required: v_o=0 and m=0 throughout.
- Single block:
  - Stimulus: k=0x00000000000000000000, c=0x5579C1387B228445, v_i=1 for one cycle.
  - Required: v_o=1 for exactly one cycle, 64 cycles later, with m=0x0000000000000000; m holds that value afterwards.
- Back-to-back, four consecutive cycles, each (k, c) pair below:
  - (0, 0x5579C1387B228445)
  - (0xFFFF…FF, 0xE72C46C0F5945049)
  - (0, 0xA112FFC72F68417B)
  - (0xFFFF…FF, 0x3333DCD3213210D2)
  - Required: four consecutive v_o=1 cycles with m = 0, 0, 0xFFFFFFFFFFFFFFFF, 0xFFFFFFFFFFFFFFFF, in order.
- Bubbles:
  - Stimulus: v_i pattern 1,0,1,1,0,1 with the vector-file data; Z on k and c during the 0 cycles.
  - Required: v_o shows the same pattern delayed by 64; m never shows X and holds its value through the bubbles.
- Reset mid-flight:
  - Stimulus: three valid blocks, then rst=1 for one cycle 20 cycles later.
  - Required: v_o stays 0 for the following 64 cycles and m=0.
  - A block issued after reset still emerges correctly at +64.
- Round trip:
  - Stimulus: encrypt_pipe output c feeds decrypt_pipe, with k delayed by N_R+1 cycles, over all N_V vectors.
  - Required: m equals the original vectors_m entries after a total latency of N_R+1+N_L.
